// File: rtl/gpio_axil_if.sv
// AXI4-Lite port bundle for the GPIO bank; the bus master drives the request side.
interface gpio_axil_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/gpio_axil.sv
// AXI4-Lite GPIO bank: DATA_OUT/DIR/DATA_IN, atomic SET/CLR, byte strobes, input synchronisers.
// Define GPIO_IRQ_EN to add edge-triggered interrupts (IRQ_EN/IRQ_STATUS/IRQ_EDGE and irq).
module gpio_axil #(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned NUM_PINS    = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  gpio_axil_if.slave          s_axil,
  output logic [NUM_PINS-1:0] gpio_o,
  output logic [NUM_PINS-1:0] gpio_oe,
  input  logic [NUM_PINS-1:0] gpio_i,
  output logic                irq
);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  localparam logic [2:0] IDX_DOUT = 3'd0;
  localparam logic [2:0] IDX_DIR  = 3'd1;
  localparam logic [2:0] IDX_DIN  = 3'd2;
  localparam logic [2:0] IDX_SET  = 3'd3;
  localparam logic [2:0] IDX_CLR  = 3'd4;
  localparam logic [2:0] IDX_EN   = 3'd5;
  localparam logic [2:0] IDX_STS  = 3'd6;
  localparam logic [2:0] IDX_EDGE = 3'd7;

  logic [0:0]            wstate_q, wstate_d, rstate_q, rstate_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [2:0]            aw_idx_q, aw_idx_d;
  logic [NUM_PINS-1:0]   w_data_q, w_data_d, w_mask_q, w_mask_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_PINS-1:0]   dout_q, dout_d, dir_q, dir_d;
  logic [NUM_PINS-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0]   sync_d [SYNC_STAGES];

  logic [STRB_WIDTH-1:0] wstrb_c;
  logic [NUM_PINS-1:0]   strb_mask_c, wr_bits_c, data_in_c;
  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] rd_val_c;
  logic                  unused_c;

  assign wstrb_c   = s_axil.wstrb;
  assign wr_bits_c = w_data_q & w_mask_q;
  assign data_in_c = sync_q[SYNC_STAGES-1];
  assign unused_c  = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr, s_axil.araddr, s_axil.wdata};

  // Byte strobes expanded to a per-pin mask, truncated to the implemented pins
  always_comb begin
    strb_mask_c = '0;
    for (int i = 0; i < int'(NUM_PINS); i++) strb_mask_c[i] = wstrb_c[i / 8];
  end

  // Write channel: AW and W captured independently, update fires once both are held
  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_mask_d  = w_mask_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    wr_en_c   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          wr_en_c   = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          wstate_d  = W_RESP;
        end else begin
          if (awready_q && s_axil.awvalid) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axil.awaddr[4:2];
          end
          if (wready_q && s_axil.wvalid) begin
            w_held_d = 1'b1;
            w_data_d = s_axil.wdata[NUM_PINS-1:0];
            w_mask_d = strb_mask_c;
          end
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_RESP: begin
        if (s_axil.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Output registers: plain rw, SET ORs in, CLR clears, all under the byte mask
  always_comb begin
    dout_d = dout_q;
    dir_d  = dir_q;
    if (wr_en_c) begin
      case (aw_idx_q)
        IDX_DOUT: dout_d = (dout_q & ~w_mask_q) | wr_bits_c;
        IDX_DIR:  dir_d  = (dir_q & ~w_mask_q) | wr_bits_c;
        IDX_SET:  dout_d = dout_q | wr_bits_c;
        IDX_CLR:  dout_d = dout_q & ~wr_bits_c;
        default:  ;
      endcase
    end
  end

  always_comb begin
    sync_d[0] = gpio_i;
    for (int i = 1; i < int'(SYNC_STAGES); i++) sync_d[i] = sync_q[i-1];
  end

`ifdef GPIO_IRQ_EN
  localparam int unsigned       ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [NUM_PINS-1:0] irq_en_q, irq_en_d, irq_sts_q, irq_sts_d, irq_edge_q, irq_edge_d;
  logic [NUM_PINS-1:0] prev_q, prev_d, hit_c;
  logic [ARM_W-1:0]    arm_q, arm_d;
  logic                irq_q, irq_d;

  // Edge detector stays masked until the synchroniser has flushed its reset contents
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_edge_d = irq_edge_q;
    irq_sts_d  = irq_sts_q;
    prev_d     = data_in_c;
    arm_d      = (arm_q == ARM_DONE) ? arm_q : arm_q + ARM_W'(1);
    hit_c      = '0;
    if (arm_q == ARM_DONE)
      hit_c = (irq_edge_q & data_in_c & ~prev_q) | (~irq_edge_q & ~data_in_c & prev_q);
    if (wr_en_c) begin
      case (aw_idx_q)
        IDX_EN:   irq_en_d   = (irq_en_q & ~w_mask_q) | wr_bits_c;
        IDX_EDGE: irq_edge_d = (irq_edge_q & ~w_mask_q) | wr_bits_c;
        IDX_STS:  irq_sts_d  = irq_sts_q & ~wr_bits_c;
        default:  ;
      endcase
    end
    // A new edge wins over a simultaneous W1C of the same bit
    irq_sts_d = irq_sts_d | hit_c;
    irq_d     = |(irq_sts_q & irq_en_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q   <= '0;
      irq_edge_q <= '0;
      irq_sts_q  <= '0;
      prev_q     <= '0;
      arm_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_edge_q <= irq_edge_d;
      irq_sts_q  <= irq_sts_d;
      prev_q     <= prev_d;
      arm_q      <= arm_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val_c = '0;
    case (s_axil.araddr[4:2])
      IDX_DOUT: rd_val_c = DATA_WIDTH'(dout_q);
      IDX_DIR:  rd_val_c = DATA_WIDTH'(dir_q);
      IDX_DIN:  rd_val_c = DATA_WIDTH'(data_in_c);
`ifdef GPIO_IRQ_EN
      IDX_EN:   rd_val_c = DATA_WIDTH'(irq_en_q);
      IDX_STS:  rd_val_c = DATA_WIDTH'(irq_sts_q);
      IDX_EDGE: rd_val_c = DATA_WIDTH'(irq_edge_q);
`endif
      default:  rd_val_c = '0;
    endcase
  end

  // Read channel: sample register on AR handshake, hold rdata/rvalid until rready
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready_q && s_axil.arvalid) begin
          rdata_d   = rd_val_c;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rstate_d  = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rstate_d  = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_mask_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      dout_q    <= '0;
      dir_q     <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      w_data_q  <= w_data_d;
      w_mask_q  <= w_mask_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      dout_q    <= dout_d;
      dir_q     <= dir_d;
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_d[i];
    end
  end

  assign gpio_o         = dout_q;
  assign gpio_oe        = dir_q;
  assign s_axil.awready = awready_q;
  assign s_axil.wready  = wready_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = 2'b00;
  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = 2'b00;

endmodule
